mux_n_reg: RTL and testbench



---
 rtl/nrisc_pkg.sv | 23 ++
 rtl/mux_n_reg_if.sv | 46 ++++
 rtl/mux_n_skid.sv | 60 ++++++
 rtl/mux_n_reg.sv | 79 +++++++
 tb/tb_mux_n_reg.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nrisc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nrisc_pkg
// Description : Shared widths and a constant log2 helper for the nrisc datapath
// Revision    : 1.0 - initial release
// ============================================================================
package nrisc_pkg;

    localparam int W_DEF     = 3;
    localparam int SEL_W_DEF = 2;

    // Ceil(log2(value)), with a floor of 1 so a 2-way select still gets a bit
    function automatic int clog2_f(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_n_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_n_reg_if
// Description : Channel inputs, select and registered output of mux_n_reg.
//               err_cnt exists only when MUX_N_REG_ERRCNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_n_reg_if
    import nrisc_pkg::*;
#(
    parameter int N  = 3,
    parameter int W  = W_DEF,
    parameter int SW = SEL_W_DEF,
    parameter int CW = 8
);

    logic [N*W-1:0] entr;
    logic [N-1:0]   entr_valid;
    logic [N-1:0]   entr_ready;
    logic [SW-1:0]  sinal;
    logic [W-1:0]   saida;
    logic           saida_valid;
    logic           saida_ready;
    logic           sel_err;
`ifdef MUX_N_REG_ERRCNT_EN
    logic [CW-1:0]  err_cnt;
`endif

    modport master (
        output entr, entr_valid, sinal, saida_ready,
        input  entr_ready, saida, saida_valid, sel_err
`ifdef MUX_N_REG_ERRCNT_EN
        , input err_cnt
`endif
    );

    modport slave (
        input  entr, entr_valid, sinal, saida_ready,
        output entr_ready, saida, saida_valid, sel_err
`ifdef MUX_N_REG_ERRCNT_EN
        , output err_cnt
`endif
    );

endinterface
`default_nettype wire

// File: rtl/mux_n_skid.sv
`default_nettype none
// ============================================================================
// Module      : mux_n_skid
// Description : W-bit output register plus one skid entry with valid/ready
// Revision    : 1.0 - initial release
// ============================================================================
module mux_n_skid #(
    parameter int W = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] i_data,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    input  logic         i_ready
);

    logic [W-1:0] r_main;
    logic [W-1:0] r_skid;
    logic         r_main_vld;
    logic         r_skid_full;
    logic         w_acc;
    logic         w_main_free;

    // Ready looks only at skid occupancy, so an accept can never coincide
    // with a skid drain; the skid refills one cycle later at the earliest.
    assign o_ready     = !r_skid_full;
    assign w_acc       = i_valid && !r_skid_full;
    assign w_main_free = !r_main_vld || i_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_main      <= '0;
            r_skid      <= '0;
            r_main_vld  <= 1'b0;
            r_skid_full <= 1'b0;
        end else if (w_main_free) begin
            if (r_skid_full) begin
                r_main      <= r_skid;
                r_main_vld  <= 1'b1;
                r_skid_full <= 1'b0;
            end else if (w_acc) begin
                r_main     <= i_data;
                r_main_vld <= 1'b1;
            end else begin
                r_main_vld <= 1'b0;
            end
        end else if (w_acc) begin
            r_skid      <= i_data;
            r_skid_full <= 1'b1;
        end
    end

    assign o_data  = r_main;
    assign o_valid = r_main_vld;

endmodule
`default_nettype wire

// File: rtl/mux_n_reg.sv
`default_nettype none
// ============================================================================
// Module      : mux_n_reg
// Description : N-input W-bit registered selector with skid buffer and
//               out-of-range select detection. Define MUX_N_REG_ERRCNT_EN
//               to add the saturating err_cnt counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_n_reg
    import nrisc_pkg::*;
#(
    parameter int N  = 3,
    parameter int W  = W_DEF,
    parameter int SW = clog2_f(N),
    parameter int CW = 8
) (
    input  logic        clock,
    input  logic        reset,
    mux_n_reg_if.slave  bus
);

    localparam logic [SW:0] C_N = (SW+1)'(N);

    logic [SW-1:0] w_sel_eff;
    logic          w_sel_oor;
    logic [W-1:0]  w_data;
    logic          w_in_valid;
    logic          w_skid_ready;
    logic          w_acc;
    logic          r_sel_err;

    // Out-of-range selects fall back to channel 0
    assign w_sel_oor  = ({1'b0, bus.sinal} >= C_N);
    assign w_sel_eff  = w_sel_oor ? '0 : bus.sinal;
    assign w_data     = bus.entr[int'(w_sel_eff)*W +: W];
    assign w_in_valid = bus.entr_valid[w_sel_eff] && !reset;
    assign w_acc      = w_in_valid && w_skid_ready;

    assign bus.entr_ready = (reset || !w_skid_ready) ? '0 : (N'(1) << w_sel_eff);

    mux_n_skid #(
        .W (W)
    ) u_skid (
        .clock   (clock),
        .reset   (reset),
        .i_data  (w_data),
        .i_valid (w_in_valid),
        .o_ready (w_skid_ready),
        .o_data  (bus.saida),
        .o_valid (bus.saida_valid),
        .i_ready (bus.saida_ready)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sel_err <= 1'b0;
        end else if (w_acc && w_sel_oor) begin
            r_sel_err <= 1'b1;
        end
    end

    assign bus.sel_err = r_sel_err;

`ifdef MUX_N_REG_ERRCNT_EN
    logic [CW-1:0] r_err_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_err_cnt <= '0;
        end else if (w_acc && w_sel_oor && (r_err_cnt != {CW{1'b1}})) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign bus.err_cnt = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_n_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_n_reg
// Description : Self-checking bench for mux_n_reg (default and N=5/W=16)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_n_reg;

    localparam int AN = 3, AW = 3,  ASW = 2;
    localparam int BN = 5, BW = 16, BSW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux_n_reg_if #(.N(AN), .W(AW), .SW(ASW), .CW(8)) ifa ();
    mux_n_reg_if #(.N(BN), .W(BW), .SW(BSW), .CW(8)) ifb ();

    mux_n_reg #(.N(AN), .W(AW), .SW(ASW), .CW(8)) u_dut_a (
        .clock (clk),
        .reset (rst),
        .bus   (ifa)
    );

    mux_n_reg #(.N(BN), .W(BW), .SW(BSW), .CW(8)) u_dut_b (
        .clock (clk),
        .reset (rst),
        .bus   (ifb)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference FIFO models: occupancy 0..2 and queue of expected beats
    int          occ_a = 0, cnt_a = 0, sa;
    logic        err_a = 1'b0, acc_a;
    logic [AN-1:0] er_a;
    logic [AW-1:0] q_a[$];

    int          occ_b = 0, cnt_b = 0, sb;
    logic        err_b = 1'b0, acc_b;
    logic [BN-1:0] er_b;
    logic [BW-1:0] q_b[$];

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                n_total++;
                if (ifa.entr_ready !== '0) $display("FAIL a_ready_in_reset got %b exp 0", ifa.entr_ready);
                else n_pass++;
                occ_a = 0; cnt_a = 0; err_a = 1'b0; q_a.delete();
            end else begin
                sa   = (int'(ifa.sinal) < AN) ? int'(ifa.sinal) : 0;
                er_a = (occ_a < 2) ? (AN'(1) << sa) : '0;
                n_total++;
                if (ifa.entr_ready !== er_a) $display("FAIL a_ready got %b exp %b", ifa.entr_ready, er_a);
                else n_pass++;
                n_total++;
                if (ifa.saida_valid !== (occ_a > 0)) $display("FAIL a_valid got %b exp %0d", ifa.saida_valid, occ_a > 0);
                else n_pass++;
                if (occ_a > 0) begin
                    n_total++;
                    if (ifa.saida !== q_a[0]) $display("FAIL a_data got %0h exp %0h", ifa.saida, q_a[0]);
                    else n_pass++;
                end
                n_total++;
                if (ifa.sel_err !== err_a) $display("FAIL a_sel_err got %b exp %b", ifa.sel_err, err_a);
                else n_pass++;
`ifdef MUX_N_REG_ERRCNT_EN
                n_total++;
                if (ifa.err_cnt !== 8'(cnt_a)) $display("FAIL a_err_cnt got %0d exp %0d", ifa.err_cnt, cnt_a);
                else n_pass++;
`endif
                acc_a = ifa.entr_valid[sa] && (occ_a < 2);
                if (occ_a > 0 && ifa.saida_ready) begin
                    void'(q_a.pop_front());
                    occ_a--;
                end
                if (acc_a) begin
                    q_a.push_back(ifa.entr[sa*AW +: AW]);
                    occ_a++;
                    if (int'(ifa.sinal) >= AN) begin
                        err_a = 1'b1;
                        if (cnt_a < 255) cnt_a++;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                occ_b = 0; cnt_b = 0; err_b = 1'b0; q_b.delete();
            end else begin
                sb   = (int'(ifb.sinal) < BN) ? int'(ifb.sinal) : 0;
                er_b = (occ_b < 2) ? (BN'(1) << sb) : '0;
                n_total++;
                if (!$onehot0(ifb.entr_ready) || ifb.entr_ready !== er_b)
                    $display("FAIL b_ready got %b exp %b", ifb.entr_ready, er_b);
                else n_pass++;
                n_total++;
                if (ifb.saida_valid !== (occ_b > 0)) $display("FAIL b_valid got %b exp %0d", ifb.saida_valid, occ_b > 0);
                else n_pass++;
                if (occ_b > 0) begin
                    n_total++;
                    if (ifb.saida !== q_b[0]) $display("FAIL b_data got %0h exp %0h", ifb.saida, q_b[0]);
                    else n_pass++;
                end
                n_total++;
                if (ifb.sel_err !== err_b) $display("FAIL b_sel_err got %b exp %b", ifb.sel_err, err_b);
                else n_pass++;
`ifdef MUX_N_REG_ERRCNT_EN
                n_total++;
                if (ifb.err_cnt !== 8'(cnt_b)) $display("FAIL b_err_cnt got %0d exp %0d", ifb.err_cnt, cnt_b);
                else n_pass++;
`endif
                acc_b = ifb.entr_valid[sb] && (occ_b < 2);
                if (occ_b > 0 && ifb.saida_ready) begin
                    void'(q_b.pop_front());
                    occ_b--;
                end
                if (acc_b) begin
                    q_b.push_back(ifb.entr[sb*BW +: BW]);
                    occ_b++;
                    if (int'(ifb.sinal) >= BN) begin
                        err_b = 1'b1;
                        if (cnt_b < 255) cnt_b++;
                    end
                end
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        #1;
        n_total++;
        if (ifa.saida_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", ifa.saida_valid);
        else n_pass++;
        n_total++;
        if (ifa.saida !== 3'd0) $display("FAIL reset_data got %0d exp 0", ifa.saida);
        else n_pass++;
        n_total++;
        if (ifa.entr_ready !== 3'b001) $display("FAIL reset_ready got %b exp 001", ifa.entr_ready);
        else n_pass++;
    endtask

    task automatic test_basic();
        ifa.entr        = {3'd3, 3'd2, 3'd1};
        ifa.entr_valid  = 3'b111;
        ifa.saida_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ifa.sinal = 2'(k);
            cyc();
            n_total++;
            if (ifa.saida !== 3'(k + 1) || ifa.saida_valid !== 1'b1)
                $display("FAIL basic_ch%0d got %0d/%b exp %0d/1", k, ifa.saida, ifa.saida_valid, k + 1);
            else n_pass++;
        end
    endtask

    task automatic test_sel_err();
        ifa.entr  = {3'd3, 3'd2, 3'd4};
        ifa.sinal = 2'd3;
        cyc();
        n_total++;
        if (ifa.saida !== 3'd4 || ifa.sel_err !== 1'b1)
            $display("FAIL sel_err_first got %0d/%b exp 4/1", ifa.saida, ifa.sel_err);
        else n_pass++;
`ifdef MUX_N_REG_ERRCNT_EN
        n_total++;
        if (ifa.err_cnt !== 8'd1) $display("FAIL err_cnt_first got %0d exp 1", ifa.err_cnt);
        else n_pass++;
`endif
        cyc(299);
`ifdef MUX_N_REG_ERRCNT_EN
        n_total++;
        if (ifa.err_cnt !== 8'd255) $display("FAIL err_cnt_sat got %0d exp 255", ifa.err_cnt);
        else n_pass++;
`endif
        n_total++;
        if (ifa.sel_err !== 1'b1) $display("FAIL sel_err_sticky got %b exp 1", ifa.sel_err);
        else n_pass++;
        ifa.sinal = 2'd0;
    endtask

    task automatic test_stall();
        ifa.entr_valid  = 3'b000;
        ifa.saida_ready = 1'b1;
        cyc(2);
        ifa.saida_ready = 1'b0;
        ifa.entr_valid  = 3'b111;
        ifa.sinal       = 2'd1;
        ifa.entr        = {3'd0, 3'd5, 3'd0};
        cyc();
        n_total++;
        if (ifa.saida !== 3'd5 || ifa.entr_ready !== 3'b010)
            $display("FAIL stall_first got %0d/%b exp 5/010", ifa.saida, ifa.entr_ready);
        else n_pass++;
        ifa.entr = {3'd0, 3'd6, 3'd0};
        cyc();
        n_total++;
        if (ifa.entr_ready !== 3'b000) $display("FAIL stall_full_ready got %b exp 000", ifa.entr_ready);
        else n_pass++;
        ifa.entr = {3'd0, 3'd7, 3'd0};
        cyc();
        n_total++;
        if (ifa.saida !== 3'd5 || ifa.saida_valid !== 1'b1)
            $display("FAIL stall_hold got %0d/%b exp 5/1", ifa.saida, ifa.saida_valid);
        else n_pass++;
        ifa.saida_ready = 1'b1;
        ifa.entr_valid  = 3'b000;
        cyc();
        n_total++;
        if (ifa.saida !== 3'd6 || ifa.entr_ready !== 3'b010)
            $display("FAIL stall_release got %0d/%b exp 6/010", ifa.saida, ifa.entr_ready);
        else n_pass++;
        cyc();
        n_total++;
        if (ifa.saida_valid !== 1'b0) $display("FAIL stall_drained got %b exp 0", ifa.saida_valid);
        else n_pass++;
    endtask

    task automatic test_reset_full();
        ifa.saida_ready = 1'b0;
        ifa.entr_valid  = 3'b111;
        ifa.sinal       = 2'd3;
        ifa.entr        = {3'd1, 3'd1, 3'd2};
        cyc(2);
        n_total++;
        if (ifa.entr_ready !== 3'b000 || ifa.sel_err !== 1'b1)
            $display("FAIL prereset_full got %b/%b exp 000/1", ifa.entr_ready, ifa.sel_err);
        else n_pass++;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        n_total++;
        if (ifa.saida_valid !== 1'b0 || ifa.saida !== 3'd0 || ifa.sel_err !== 1'b0)
            $display("FAIL reset_full got %b/%0d/%b exp 0/0/0", ifa.saida_valid, ifa.saida, ifa.sel_err);
        else n_pass++;
        n_total++;
        if (ifa.entr_ready !== 3'b001) $display("FAIL reset_full_ready got %b exp 001", ifa.entr_ready);
        else n_pass++;
        ifa.entr_valid  = 3'b000;
        ifa.saida_ready = 1'b1;
        cyc(3);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10000; i++) begin
            ifb.sinal       = 3'($urandom_range(0, 7));
            ifb.entr_valid  = 5'($urandom);
            ifb.entr        = 80'({$urandom, $urandom, $urandom});
            ifb.saida_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        ifb.entr_valid  = '0;
        ifb.saida_ready = 1'b1;
        cyc(3);
        n_total++;
        if (ifb.saida_valid !== 1'b0) $display("FAIL random_drain got %b exp 0", ifb.saida_valid);
        else n_pass++;
    endtask

    initial begin
        ifa.entr = '0; ifa.entr_valid = '0; ifa.sinal = '0; ifa.saida_ready = 1'b1;
        ifb.entr = '0; ifb.entr_valid = '0; ifb.sinal = '0; ifb.saida_ready = 1'b1;
        test_reset();
        test_basic();
        test_sel_err();
        test_stall();
        test_reset_full();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
